alu_ctrl_seq: RTL and testbench
===============================

// Module: alu_ctrl_seq
// PURPOSE
//  Parametrised, registered ALU control unit for the RV32I core, extended with RV32M decode, SLT/SLTU and AUIPC.
//  Sequences multi-cycle multiply/divide over a valid/ready handshake with a fixed-latency busy counter.
//  Sits between the main decoder (aluOp, funct fields, opcode) and the ALU/MDU datapath; drives the pipeline stall.
// PARAMETERS
//  ENABLE_M   1   1: decode RV32M; 0: funct7=0000001 R-type flagged illegal
//  MUL_LAT    3   cycles from accept to out_valid for MUL* (>=1)
//  DIV_LAT    33  cycles from accept to out_valid for DIV*/REM* (>=1)
//  CTRL_W     5   aluControl width (>=5)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  flush        in   1       synchronous abort of the current op
//  in_valid     in   1       decode fields valid
//  in_ready     out  1       unit can accept this cycle
//  aluOp        in   2       00 mem, 01 R/I arith, 10 branch, 11 upper-imm
//  funct7       in   7       instruction[31:25]
//  funct3       in   3       instruction[14:12]
//  instOpcode   in   7       instruction[6:0]
//  aluControl   out  CTRL_W  registered ALU/MDU operation code
//  out_valid    out  1       aluControl result ready (1-cycle pulse)
//  mdu_start    out  1       1-cycle pulse launching MDU op
//  stall        out  1       high while MUL/DIV busy
//  illegal_inst out  1       1-cycle pulse with out_valid on undecodable op
// BEHAVIOUR
//  Codes: add 00000 sub 00001 sll 00010 xor 00011 srl 00100 sra 00101 or 00110 and 00111 sltu 01000
//   beq 01001 bne 01010 lui 01011 bge 01100 bltu 01101 bgeu 01110 blt 01111 mul 10000 mulh 10001
//   mulhsu 10010 mulhu 10011 div 10100 divu 10101 rem 10110 remu 10111 slt 11000 illegal 11111.
//  Decode: aluOp 00 -> add. aluOp 01: opcode 0110011 & funct7 0000001 -> M op indexed by funct3;
//   funct7 0100000 & opcode 0110011 -> funct3 101 sra, 000 sub; opcode 0010011 & funct7 0100000 & funct3 101 -> sra;
//   else funct3 000 add,001 sll,010 slt,011 sltu,100 xor,101 srl,110 or,111 and. Any other funct7 on R-type -> illegal.
//  aluOp 10: funct3 000 beq,001 bne,100 blt,101 bge,110 bltu,111 bgeu, 010/011 illegal. aluOp 11: opcode 0010111 add, else lui.
//  FSM IDLE/BUSY. Reset: IDLE, aluControl=0, out_valid=0, mdu_start=0, stall=0, illegal_inst=0, count=0.
//  IDLE: in_ready=1. Accept at edge T when in_valid&in_ready&!flush; aluControl registered at T+1.
//   Single-cycle op: out_valid=1 at T+1, stay IDLE (throughput 1/cycle, back-to-back accepts legal).
//   MUL/DIV with LAT=L: mdu_start=1 at T+1; if L==1 out_valid at T+1, stay IDLE;
//   else BUSY, count=L-1, in_ready=0, stall=1.
//  BUSY: count decrements per cycle; count reaching 1 -> next cycle out_valid=1, FSM IDLE, stall=0 (out_valid at T+L).
//  aluControl holds its value until the next accept; in_valid ignored while BUSY.
//  Illegal: aluControl=11111, out_valid=1 and illegal_inst=1 at T+1, never enters BUSY, no mdu_start.
//  flush: highest priority after reset; next cycle IDLE, count=0, out_valid/mdu_start/stall=0,
//   aluControl retained; flush in the same cycle as in_valid drops the instruction.
//  reset mid-BUSY: all outputs to reset values next edge; no out_valid for the aborted op.
// TESTING
//  add: aluOp 01, opc 0110011, f7 0, f3 000, valid at T -> aluControl 00000, out_valid at T+1, stall never high.
//  Back-to-back: sub then srai (f7 0100000,f3 101,opc 0010011) on consecutive cycles -> 00001, 00101 in consecutive out_valid.
//  DIV_LAT=33: div (f7 0000001,f3 100) at T -> mdu_start T+1, stall T+1..T+32, out_valid T+33, code 10100.
//  ENABLE_M=0: mul -> aluControl 11111, illegal_inst & out_valid at T+1, mdu_start 0.
//  flush at T+5 during divide -> stall low at T+6, no out_valid; next add accepted at T+6 gives out_valid T+7.
//  reset at T+2 during mul, branch f3 010, aluOp 11 opc 0010111 -> reset values; illegal 11111; add 00000.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// Registered ALU/MDU control unit for the RV32I(+M) core: decodes aluOp/funct fields into an
// operation code and sequences fixed-latency multiply/divide, stalling the pipeline while busy.
module alu_ctrl_seq #(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 3,
  parameter int DIV_LAT  = 33,
  parameter int CTRL_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        aluOp,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic [6:0]        instOpcode,
  output logic [CTRL_W-1:0] aluControl,
  output logic              out_valid,
  output logic              mdu_start,
  output logic              stall,
  output logic              illegal_inst
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_M      = 7'b0000001;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_SLL  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SRL  = 5'b00100;
  localparam logic [4:0] OP_SRA  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b00111;
  localparam logic [4:0] OP_SLTU = 5'b01000;
  localparam logic [4:0] OP_BEQ  = 5'b01001;
  localparam logic [4:0] OP_BNE  = 5'b01010;
  localparam logic [4:0] OP_LUI  = 5'b01011;
  localparam logic [4:0] OP_BGE  = 5'b01100;
  localparam logic [4:0] OP_BLTU = 5'b01101;
  localparam logic [4:0] OP_BGEU = 5'b01110;
  localparam logic [4:0] OP_BLT  = 5'b01111;
  localparam logic [4:0] OP_SLT  = 5'b11000;
  localparam logic [4:0] OP_ILL  = 5'b11111;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, stateNext;
  logic [CNT_W-1:0] count, countNext, latLoad;
  logic [CTRL_W-1:0] ctrlNext;
  logic             outValidNext, mduStartNext, stallNext, illegalNext;
  logic [4:0]       decCode;
  logic             isMdu, isDiv;

  // Pure decode of the incoming fields; M ops reuse funct3 as the low code bits.
  always_comb begin
    decCode = OP_ILL;
    case (aluOp)
      2'b00: decCode = OP_ADD;
      2'b01: begin
        if (instOpcode == OPC_R && funct7 == F7_M) begin
          decCode = (ENABLE_M != 0) ? {2'b10, funct3} : OP_ILL;
        end else if (instOpcode == OPC_R && funct7 == F7_ALT) begin
          if (funct3 == 3'b101)      decCode = OP_SRA;
          else if (funct3 == 3'b000) decCode = OP_SUB;
          else                       decCode = OP_ILL;
        end else if (instOpcode == OPC_R && funct7 != F7_BASE) begin
          decCode = OP_ILL;
        end else if (instOpcode == OPC_I && funct7 == F7_ALT && funct3 == 3'b101) begin
          decCode = OP_SRA;
        end else begin
          case (funct3)
            3'b000:  decCode = OP_ADD;
            3'b001:  decCode = OP_SLL;
            3'b010:  decCode = OP_SLT;
            3'b011:  decCode = OP_SLTU;
            3'b100:  decCode = OP_XOR;
            3'b101:  decCode = OP_SRL;
            3'b110:  decCode = OP_OR;
            default: decCode = OP_AND;
          endcase
        end
      end
      2'b10: begin
        case (funct3)
          3'b000:  decCode = OP_BEQ;
          3'b001:  decCode = OP_BNE;
          3'b100:  decCode = OP_BLT;
          3'b101:  decCode = OP_BGE;
          3'b110:  decCode = OP_BLTU;
          3'b111:  decCode = OP_BGEU;
          default: decCode = OP_ILL;
        endcase
      end
      default: decCode = (instOpcode == OPC_AUIPC) ? OP_ADD : OP_LUI;
    endcase
  end

  assign isMdu    = (decCode[4:3] == 2'b10);
  assign isDiv    = decCode[2];
  assign latLoad  = isDiv ? DIV_LOAD : MUL_LOAD;
  assign in_ready = (state == IDLE);

  // Next-state and next-output logic; flush wins over everything except reset.
  always_comb begin
    stateNext    = state;
    countNext    = count;
    ctrlNext     = aluControl;
    outValidNext = 1'b0;
    mduStartNext = 1'b0;
    stallNext    = 1'b0;
    illegalNext  = 1'b0;
    if (flush) begin
      stateNext = IDLE;
      countNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ctrlNext    = CTRL_W'(decCode);
            illegalNext = (decCode == OP_ILL);
            if (isMdu) begin
              mduStartNext = 1'b1;
              if (latLoad == '0) begin
                outValidNext = 1'b1;
              end else begin
                stateNext = BUSY;
                countNext = latLoad;
                stallNext = 1'b1;
              end
            end else begin
              outValidNext = 1'b1;
            end
          end
        end
        default: begin
          if (count <= CNT_W'(1)) begin
            stateNext    = IDLE;
            countNext    = '0;
            outValidNext = 1'b1;
          end else begin
            countNext = count - CNT_W'(1);
            stallNext = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      aluControl   <= '0;
      out_valid    <= 1'b0;
      mdu_start    <= 1'b0;
      stall        <= 1'b0;
      illegal_inst <= 1'b0;
    end else begin
      state        <= stateNext;
      count        <= countNext;
      aluControl   <= ctrlNext;
      out_valid    <= outValidNext;
      mdu_start    <= mduStartNext;
      stall        <= stallNext;
      illegal_inst <= illegalNext;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq: decode table, back-to-back issue, MUL/DIV
// sequencing, flush and reset aborts, plus an ENABLE_M=0 instance sharing the same inputs.
module tb_alu_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset, flush, in_valid;
  logic [1:0] aluOp;
  logic [6:0] funct7, instOpcode;
  logic [2:0] funct3;

  logic       in_ready, out_valid, mdu_start, stall, illegal_inst;
  logic [4:0] aluControl;
  logic       in_readyN, out_validN, mdu_startN, stallN, illegal_instN;
  logic [4:0] aluControlN;

  int checkCount = 0;
  int errorCount = 0;

  alu_ctrl_seq #(.ENABLE_M(1), .MUL_LAT(3), .DIV_LAT(33), .CTRL_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .funct7(funct7), .funct3(funct3), .instOpcode(instOpcode),
    .aluControl(aluControl), .out_valid(out_valid), .mdu_start(mdu_start),
    .stall(stall), .illegal_inst(illegal_inst)
  );

  alu_ctrl_seq #(.ENABLE_M(0), .MUL_LAT(3), .DIV_LAT(33), .CTRL_W(5)) dutNoM (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_readyN),
    .aluOp(aluOp), .funct7(funct7), .funct3(funct3), .instOpcode(instOpcode),
    .aluControl(aluControlN), .out_valid(out_validN), .mdu_start(mdu_startN),
    .stall(stallN), .illegal_inst(illegal_instN)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                               input logic [6:0] opc);
    in_valid   = 1'b1;
    aluOp      = op;
    funct7     = f7;
    funct3     = f3;
    instOpcode = opc;
  endtask

  // Issue one single-cycle op and check the registered result on the following cycle.
  task automatic runVector(input string tag, input logic [1:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [6:0] opc,
                           input logic [4:0] expCode, input logic expIll);
    applyStimulus(op, f7, f3, opc);
    tick();
    checkOutput({tag, "_code"}, 32'(aluControl), 32'(expCode));
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_ill"}, 32'(illegal_inst), 32'(expIll));
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    aluOp = 2'b00; funct7 = 7'd0; funct3 = 3'd0; instOpcode = 7'd0;
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst_code", 32'(aluControl), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_start", 32'(mdu_start), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_ill", 32'(illegal_inst), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);

    runVector("add", 2'b01, 7'b0000000, 3'b000, 7'b0110011, 5'b00000, 1'b0);
    checkOutput("add_start", 32'(mdu_start), 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("add_pulse", 32'(out_valid), 32'd0);

    // Back-to-back single-cycle issue across the decode table
    runVector("sub",  2'b01, 7'b0100000, 3'b000, 7'b0110011, 5'b00001, 1'b0);
    runVector("srai", 2'b01, 7'b0100000, 3'b101, 7'b0010011, 5'b00101, 1'b0);
    runVector("sll",  2'b01, 7'b0000000, 3'b001, 7'b0110011, 5'b00010, 1'b0);
    runVector("slt",  2'b01, 7'b0000000, 3'b010, 7'b0110011, 5'b11000, 1'b0);
    runVector("sltu", 2'b01, 7'b0000000, 3'b011, 7'b0110011, 5'b01000, 1'b0);
    runVector("xor",  2'b01, 7'b0000000, 3'b100, 7'b0110011, 5'b00011, 1'b0);
    runVector("srl",  2'b01, 7'b0000000, 3'b101, 7'b0110011, 5'b00100, 1'b0);
    runVector("sra",  2'b01, 7'b0100000, 3'b101, 7'b0110011, 5'b00101, 1'b0);
    runVector("or",   2'b01, 7'b0000000, 3'b110, 7'b0110011, 5'b00110, 1'b0);
    runVector("and",  2'b01, 7'b0000000, 3'b111, 7'b0110011, 5'b00111, 1'b0);
    runVector("addi", 2'b01, 7'b0101010, 3'b000, 7'b0010011, 5'b00000, 1'b0);
    runVector("srli", 2'b01, 7'b0000000, 3'b101, 7'b0010011, 5'b00100, 1'b0);
    runVector("badf7", 2'b01, 7'b0000010, 3'b000, 7'b0110011, 5'b11111, 1'b1);
    runVector("lw",   2'b00, 7'b1111111, 3'b010, 7'b0000011, 5'b00000, 1'b0);
    runVector("beq",  2'b10, 7'b0000000, 3'b000, 7'b1100011, 5'b01001, 1'b0);
    runVector("bne",  2'b10, 7'b0000000, 3'b001, 7'b1100011, 5'b01010, 1'b0);
    runVector("blt",  2'b10, 7'b0000000, 3'b100, 7'b1100011, 5'b01111, 1'b0);
    runVector("bge",  2'b10, 7'b0000000, 3'b101, 7'b1100011, 5'b01100, 1'b0);
    runVector("bltu", 2'b10, 7'b0000000, 3'b110, 7'b1100011, 5'b01101, 1'b0);
    runVector("bgeu", 2'b10, 7'b0000000, 3'b111, 7'b1100011, 5'b01110, 1'b0);
    runVector("lui",  2'b11, 7'b0000000, 3'b000, 7'b0110111, 5'b01011, 1'b0);
    in_valid = 1'b0;
    tick();

    // MUL, latency 3; in_valid held during BUSY must be ignored
    applyStimulus(2'b01, 7'b0000001, 3'b000, 7'b0110011);
    tick();
    checkOutput("mul_start", 32'(mdu_start), 32'd1);
    checkOutput("mul_stall1", 32'(stall), 32'd1);
    checkOutput("mul_ready", 32'(in_ready), 32'd0);
    checkOutput("mul_valid1", 32'(out_valid), 32'd0);
    checkOutput("mul_code1", 32'(aluControl), 32'h10);
    checkOutput("noM_code", 32'(aluControlN), 32'h1f);
    checkOutput("noM_ill", 32'(illegal_instN), 32'd1);
    checkOutput("noM_valid", 32'(out_validN), 32'd1);
    checkOutput("noM_start", 32'(mdu_startN), 32'd0);
    checkOutput("noM_stall", 32'(stallN), 32'd0);
    applyStimulus(2'b01, 7'b0000000, 3'b100, 7'b0110011);
    tick();
    checkOutput("mul_stall2", 32'(stall), 32'd1);
    checkOutput("mul_start2", 32'(mdu_start), 32'd0);
    checkOutput("mul_valid2", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    tick();
    checkOutput("mul_valid3", 32'(out_valid), 32'd1);
    checkOutput("mul_stall3", 32'(stall), 32'd0);
    checkOutput("mul_code3", 32'(aluControl), 32'h10);
    tick();

    // DIV, latency 33
    applyStimulus(2'b01, 7'b0000001, 3'b100, 7'b0110011);
    tick();
    in_valid = 1'b0;
    checkOutput("div_start", 32'(mdu_start), 32'd1);
    checkOutput("div_stall1", 32'(stall), 32'd1);
    checkOutput("div_code", 32'(aluControl), 32'h14);
    for (int k = 2; k <= 32; k++) begin
      tick();
      checkOutput("div_stall", 32'(stall), 32'd1);
      checkOutput("div_early", 32'(out_valid), 32'd0);
    end
    tick();
    checkOutput("div_valid", 32'(out_valid), 32'd1);
    checkOutput("div_stall33", 32'(stall), 32'd0);
    checkOutput("div_code33", 32'(aluControl), 32'h14);
    tick();
    checkOutput("div_pulse", 32'(out_valid), 32'd0);

    // Flush at T+5 of a DIVU, then an add at T+6
    applyStimulus(2'b01, 7'b0000001, 3'b101, 7'b0110011);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("fl_stall", 32'(stall), 32'd0);
    checkOutput("fl_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_ready", 32'(in_ready), 32'd1);
    checkOutput("fl_code", 32'(aluControl), 32'h15);
    runVector("fl_add", 2'b01, 7'b0000000, 3'b000, 7'b0110011, 5'b00000, 1'b0);
    in_valid = 1'b0;
    begin
      int strays = 0;
      for (int k = 0; k < 35; k++) begin
        tick();
        if (out_valid) strays++;
      end
      checkOutput("fl_noValid", 32'(strays), 32'd0);
    end

    // Flush together with in_valid drops the instruction
    applyStimulus(2'b01, 7'b0100000, 3'b000, 7'b0110011);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flv_valid", 32'(out_valid), 32'd0);
    checkOutput("flv_code", 32'(aluControl), 32'd0);

    // Reset at T+2 of a MUL
    applyStimulus(2'b01, 7'b0000001, 3'b001, 7'b0110011);
    tick();
    in_valid = 1'b0;
    checkOutput("rm_code1", 32'(aluControl), 32'h11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rm_code", 32'(aluControl), 32'd0);
    checkOutput("rm_stall", 32'(stall), 32'd0);
    checkOutput("rm_valid", 32'(out_valid), 32'd0);
    checkOutput("rm_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("rm_noValid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("rm_noValid2", 32'(out_valid), 32'd0);

    runVector("br010", 2'b10, 7'b0000000, 3'b010, 7'b1100011, 5'b11111, 1'b1);
    checkOutput("br010_start", 32'(mdu_start), 32'd0);
    runVector("auipc", 2'b11, 7'b0000000, 3'b000, 7'b0010111, 5'b00000, 1'b0);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
